// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating
// direction counters, looked up combinationally by the fetch PC and trained
// by the branch resolution stage. Also keeps a saturating mispredict counter.
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RST            synchronous active-high reset
//   cpc            fetch PC, word address [31:2]
//   bpSel          1 = predict taken, PC unit selects bp_a
//   bp_a           predicted next fetch word address
//   upd_valid      resolution stage retiring a branch this cycle
//   upd_pc         word address of the resolved branch
//   upd_taken      actual branch outcome
//   upd_target     actual taken target, word address
//   upd_mispredict prediction for this branch was wrong (qualified by upd_valid)
//   mispredict_cnt saturating count of mispredicts since reset
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [29:0]       cpc,
    output logic              bpSel,
    output logic [29:0]       bp_a,
    input  logic              upd_valid,
    input  logic [29:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [29:0]       upd_target,
    input  logic              upd_mispredict,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [29:0]       target_q [ENTRIES];

    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic              look_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;

    // Lookup from registered state only; a same-cycle update is not bypassed.
    always_comb begin
        look_idx = cpc[IDX_W-1:0];
        look_tag = cpc[29:IDX_W];
        look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        bpSel    = look_hit && ctr_q[look_idx][1];
        bp_a     = bpSel ? target_q[look_idx] : cpc + 30'd1;
    end

    always_comb begin
        upd_idx = upd_pc[IDX_W-1:0];
        upd_tag = upd_pc[29:IDX_W];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    // Table training and mispredict counting; reset wins over a same-cycle update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b00;
                target_q[i] <= '0;
            end
            mispredict_cnt <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Only taken branches allocate; they start weakly taken.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
            if (upd_mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
